// File: rtl/post_lna_pipe.sv
// Post-LNA receive/transmit pipelines with run-time modes, a differential receive
// output and a settle counter that blanks both outputs after reset or a mode change.
module post_lna_pipe #(
   parameter int WIDTH         = 8,
   parameter int STAGES        = 4,
   parameter int SETTLE_CYCLES = 3
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [1:0]       Mode,
   input  logic [WIDTH-1:0] OuterReceive,
   input  logic             OuterReceiveValid,
   output logic [WIDTH:0]   InnerReceive,
   output logic             InnerReceiveValid,
   input  logic [WIDTH-1:0] InnerTransmit,
   input  logic             InnerTransmitValid,
   output logic [WIDTH-1:0] OuterTransmit,
   output logic             OuterTransmitValid,
   output logic             Settling
);

   localparam logic [1:0] MODE_NORMAL = 2'b00;
   localparam logic [1:0] MODE_LOOP   = 2'b01;
   localparam logic [1:0] MODE_BYPASS = 2'b10;
   localparam logic [1:0] MODE_MUTE   = 2'b11;
   localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);

   typedef enum logic {SETTLE, RUN} settle_state_e;

   settle_state_e     state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [1:0]        mode_q, mode_d;
   logic              flush, bypass, bypass_q, settling;
   logic [WIDTH-1:0]  rx_in_data;
   logic              rx_in_valid, tx_in_valid;
   logic [WIDTH-1:0]  prev_q, prev_d;
   logic [WIDTH:0]    prev_ext, stage_raw;
   logic              stage_valid;
   logic [WIDTH:0]    rx_data_q [STAGES];
   logic [WIDTH:0]    rx_data_d [STAGES];
   logic [STAGES-1:0] rx_valid_q, rx_valid_d;
   logic [WIDTH-1:0]  tx_data_q [STAGES];
   logic [WIDTH-1:0]  tx_data_d [STAGES];
   logic [STAGES-1:0] tx_valid_q, tx_valid_d;
   logic              rx_last_valid, tx_last_valid, rx_out_en, tx_out_en;
   logic [WIDTH:0]    rx_last_data;
   logic [WIDTH-1:0]  tx_last_data;

   // Input steering uses the incoming Mode; a flush on this edge discards any input.
   always_comb begin
      mode_d      = Mode;
      flush       = (Mode != mode_q);
      bypass      = (Mode == MODE_BYPASS);
      rx_in_data  = OuterReceive;
      rx_in_valid = OuterReceiveValid;
      tx_in_valid = InnerTransmitValid;
      case (Mode)
         MODE_LOOP: begin
            rx_in_data  = InnerTransmit;
            rx_in_valid = InnerTransmitValid;
            tx_in_valid = 1'b0;
         end
         MODE_MUTE: begin
            rx_in_valid = 1'b0;
            tx_in_valid = 1'b0;
         end
         default: ;
      endcase
      if (flush) begin
         rx_in_valid = 1'b0;
         tx_in_valid = 1'b0;
      end
   end

   // The tap stage (stage 0 in bypass, else the last) stores the difference instead of the raw sample.
   always_comb begin
      prev_d        = prev_q;
      prev_ext      = {prev_q[WIDTH-1], prev_q};
      stage_raw     = {rx_in_data[WIDTH-1], rx_in_data};
      stage_valid   = rx_in_valid;
      rx_valid_d    = '0;
      rx_valid_d[0] = stage_valid;
      rx_data_d[0]  = stage_raw;
      if (bypass || (STAGES == 1)) begin
         rx_data_d[0] = stage_valid ? (stage_raw - prev_ext) : '0;
         if (stage_valid) prev_d = stage_raw[WIDTH-1:0];
      end
      for (int k = 1; k < STAGES; k++) begin
         stage_valid   = rx_valid_q[k-1] && !bypass && !flush;
         rx_valid_d[k] = stage_valid;
         rx_data_d[k]  = rx_data_q[k-1];
         if (k == STAGES - 1) begin
            rx_data_d[k] = stage_valid ? (rx_data_q[k-1] - prev_ext) : '0;
            if (stage_valid) prev_d = rx_data_q[k-1][WIDTH-1:0];
         end
      end
      if (flush) prev_d = '0;
   end

   always_comb begin
      tx_valid_d    = '0;
      tx_valid_d[0] = tx_in_valid;
      tx_data_d[0]  = InnerTransmit;
      for (int k = 1; k < STAGES; k++) begin
         tx_valid_d[k] = tx_valid_q[k-1] && !bypass && !flush;
         tx_data_d[k]  = tx_data_q[k-1];
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         mode_q     <= MODE_NORMAL;
         prev_q     <= '0;
         rx_valid_q <= '0;
         tx_valid_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            rx_data_q[k] <= '0;
            tx_data_q[k] <= '0;
         end
      end else begin
         mode_q     <= mode_d;
         prev_q     <= prev_d;
         rx_valid_q <= rx_valid_d;
         tx_valid_q <= tx_valid_d;
         for (int k = 0; k < STAGES; k++) begin
            rx_data_q[k] <= rx_data_d[k];
            tx_data_q[k] <= tx_data_d[k];
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= (SETTLE_CYCLES > 0) ? SETTLE : RUN;
         count_q <= SETTLE_LOAD;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (flush) begin
         count_d = SETTLE_LOAD;
         state_d = (SETTLE_CYCLES > 0) ? SETTLE : RUN;
      end else if (state_q == SETTLE) begin
         count_d = (count_q != '0) ? (count_q - CW'(1)) : '0;
         if (count_d == '0) state_d = RUN;
      end
   end

   // Output taps follow the registered mode; data is zeroed whenever its valid is blanked.
   always_comb begin
      settling           = (state_q == SETTLE);
      bypass_q           = (mode_q == MODE_BYPASS);
      rx_last_valid      = bypass_q ? rx_valid_q[0] : rx_valid_q[STAGES-1];
      rx_last_data       = bypass_q ? rx_data_q[0]  : rx_data_q[STAGES-1];
      tx_last_valid      = bypass_q ? tx_valid_q[0] : tx_valid_q[STAGES-1];
      tx_last_data       = bypass_q ? tx_data_q[0]  : tx_data_q[STAGES-1];
      rx_out_en          = rx_last_valid && !settling;
      tx_out_en          = tx_last_valid && !settling;
      Settling           = settling;
      InnerReceiveValid  = rx_out_en;
      InnerReceive       = rx_last_data & {(WIDTH+1){rx_out_en}};
      OuterTransmitValid = tx_out_en;
      OuterTransmit      = tx_last_data & {WIDTH{tx_out_en}};
   end

endmodule

// File: tb/tb_post_lna_pipe.sv
// Scenario bench for post_lna_pipe: expectations are queued when stimulus is driven
// and matched (value and arrival cycle) by a negedge monitor.
module tb_post_lna_pipe;

   localparam int WIDTH         = 8;
   localparam int STAGES        = 4;
   localparam int SETTLE_CYCLES = 3;

   logic             Clock = 1'b0;
   logic             Reset;
   logic [1:0]       Mode;
   logic [WIDTH-1:0] OuterReceive;
   logic             OuterReceiveValid;
   logic [WIDTH:0]   InnerReceive;
   logic             InnerReceiveValid;
   logic [WIDTH-1:0] InnerTransmit;
   logic             InnerTransmitValid;
   logic [WIDTH-1:0] OuterTransmit;
   logic             OuterTransmitValid;
   logic             Settling;

   typedef struct {logic [8:0] val; int cyc;} rx_exp_t;
   typedef struct {logic [7:0] val; int cyc;} tx_exp_t;

   rx_exp_t rx_q[$];
   tx_exp_t tx_q[$];
   rx_exp_t rx_e;
   tx_exp_t tx_e;
   logic signed [7:0] prev_model;
   int cycle  = 0;
   int errors = 0;
   int checks = 0;

   post_lna_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .SETTLE_CYCLES(SETTLE_CYCLES)) dut (
      .Clock(Clock), .Reset(Reset), .Mode(Mode),
      .OuterReceive(OuterReceive), .OuterReceiveValid(OuterReceiveValid),
      .InnerReceive(InnerReceive), .InnerReceiveValid(InnerReceiveValid),
      .InnerTransmit(InnerTransmit), .InnerTransmitValid(InnerTransmitValid),
      .OuterTransmit(OuterTransmit), .OuterTransmitValid(OuterTransmitValid),
      .Settling(Settling)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cycle <= cycle + 1;

   // Every valid output must match the oldest queued expectation, including its cycle.
   always @(negedge Clock) begin
      if (!Reset) begin
         if (InnerReceiveValid) begin
            checks++;
            if (rx_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL rx_unexpected: got InnerReceive=%0d at cycle %0d, required no output", $signed(InnerReceive), cycle);
            end else begin
               rx_e = rx_q.pop_front();
               if (InnerReceive !== rx_e.val || cycle != rx_e.cyc) begin
                  errors++;
                  $display("[TB] FAIL rx_data: got %0d at cycle %0d, required %0d at cycle %0d", $signed(InnerReceive), cycle, $signed(rx_e.val), rx_e.cyc);
               end
            end
         end
         if (OuterTransmitValid) begin
            checks++;
            if (tx_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL tx_unexpected: got OuterTransmit=%h at cycle %0d, required no output", OuterTransmit, cycle);
            end else begin
               tx_e = tx_q.pop_front();
               if (OuterTransmit !== tx_e.val || cycle != tx_e.cyc) begin
                  errors++;
                  $display("[TB] FAIL tx_data: got %h at cycle %0d, required %h at cycle %0d", OuterTransmit, cycle, tx_e.val, tx_e.cyc);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no end of run, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle_inputs();
      OuterReceive       = '0;
      OuterReceiveValid  = 1'b0;
      InnerTransmit      = '0;
      InnerTransmitValid = 1'b0;
   endtask

   task automatic push_rx(input logic signed [7:0] s, input int lat);
      rx_exp_t e;
      logic signed [8:0] cur, old;
      cur   = s;
      old   = prev_model;
      e.val = cur - old;
      e.cyc = cycle + lat;
      rx_q.push_back(e);
      prev_model = s;
   endtask

   task automatic push_tx(input logic [7:0] s, input int lat);
      tx_exp_t e;
      e.val = s;
      e.cyc = cycle + lat;
      tx_q.push_back(e);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      Mode  = 2'b00;
      idle_inputs();
      step();
      step();
      Reset = 1'b0;
      prev_model = '0;
      rx_q.delete();
      tx_q.delete();
   endtask

   task automatic wait_settle();
      int n = 0;
      while (Settling && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (Settling !== 1'b0) begin
         errors++;
         $display("[TB] FAIL settle_timeout: got Settling=%b after %0d cycles, required 0", Settling, n);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((rx_q.size() != 0 || tx_q.size() != 0) && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (rx_q.size() != 0 || tx_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain_timeout: got %0d rx and %0d tx pending, required 0", rx_q.size(), tx_q.size());
         rx_q.delete();
         tx_q.delete();
      end
   endtask

   task automatic set_mode(input logic [1:0] m);
      Mode = m;
      step();
      prev_model = '0;
      checks++;
      if (Settling !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_settle: got Settling=%b after mode change to %b, required 1", Settling, m);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      Mode  = 2'b00;
      idle_inputs();
      step();
      checks++;
      if (InnerReceive !== 9'd0 || InnerReceiveValid !== 1'b0 || OuterTransmit !== 8'd0 ||
          OuterTransmitValid !== 1'b0 || Settling !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_state: got rx=%h/%b tx=%h/%b settling=%b, required 0/0 0/0 1",
                  InnerReceive, InnerReceiveValid, OuterTransmit, OuterTransmitValid, Settling);
      end
      Reset = 1'b0;
      prev_model = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (Settling !== (i < 2)) begin
            errors++;
            $display("[TB] FAIL reset_settle_edge%0d: got Settling=%b, required %b", i + 1, Settling, (i < 2));
         end
      end
   endtask

   task automatic test_normal_rx();
      logic signed [7:0] samples [3];
      samples = '{8'sd10, 8'sd25, -8'sd5};
      do_reset();
      wait_settle();
      for (int i = 0; i < 3; i++) begin
         OuterReceive      = samples[i];
         OuterReceiveValid = 1'b1;
         push_rx(samples[i], STAGES);
         step();
      end
      idle_inputs();
      drain();
   endtask

   task automatic test_transmit();
      logic [7:0] samples [2];
      samples = '{8'h7F, 8'h80};
      for (int i = 0; i < 2; i++) begin
         InnerTransmit      = samples[i];
         InnerTransmitValid = 1'b1;
         push_tx(samples[i], STAGES);
         step();
      end
      idle_inputs();
      drain();
   endtask

   task automatic test_extremes();
      logic signed [7:0] samples [2];
      samples = '{8'sd127, -8'sd128};
      do_reset();
      wait_settle();
      for (int i = 0; i < 2; i++) begin
         OuterReceive      = samples[i];
         OuterReceiveValid = 1'b1;
         push_rx(samples[i], STAGES);
         step();
      end
      idle_inputs();
      drain();
   endtask

   task automatic test_loopback();
      logic signed [7:0] samples [2];
      samples = '{8'sd20, 8'sd30};
      set_mode(2'b01);
      wait_settle();
      for (int i = 0; i < 2; i++) begin
         InnerTransmit      = samples[i];
         InnerTransmitValid = 1'b1;
         OuterReceive       = 8'($urandom_range(0, 255));
         OuterReceiveValid  = 1'b1;
         push_rx(samples[i], STAGES);
         step();
      end
      InnerTransmitValid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         OuterReceive = 8'($urandom_range(0, 255));
         step();
      end
      idle_inputs();
      drain();
   endtask

   task automatic test_bypass();
      set_mode(2'b00);
      wait_settle();
      OuterReceive = 8'd50; OuterReceiveValid = 1'b1; step();
      OuterReceive = 8'd60; step();
      // Sample 99 arrives on the flush edge and must be discarded.
      Mode = 2'b10;
      OuterReceive = 8'd99;
      step();
      prev_model = '0;
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (Settling !== (i < 3)) begin
            errors++;
            $display("[TB] FAIL bypass_settle_cycle%0d: got Settling=%b, required %b", i, Settling, (i < 3));
         end
         if (i < 3) step();
      end
      OuterReceive       = 8'd7;
      OuterReceiveValid  = 1'b1;
      InnerTransmit      = 8'h33;
      InnerTransmitValid = 1'b1;
      push_rx(8'sd7, 1);
      push_tx(8'h33, 1);
      step();
      idle_inputs();
      repeat (6) step();
      drain();
   endtask

   task automatic test_mute_reset();
      set_mode(2'b11);
      for (int i = 0; i < 8; i++) begin
         OuterReceive       = 8'($urandom_range(0, 255));
         OuterReceiveValid  = 1'b1;
         InnerTransmit      = 8'($urandom_range(0, 255));
         InnerTransmitValid = 1'b1;
         step();
         checks++;
         if (InnerReceive !== 9'd0 || InnerReceiveValid !== 1'b0 ||
             OuterTransmit !== 8'd0 || OuterTransmitValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mute_outputs_cycle%0d: got rx=%h/%b tx=%h/%b, required all 0",
                     i, InnerReceive, InnerReceiveValid, OuterTransmit, OuterTransmitValid);
         end
      end
      idle_inputs();
      set_mode(2'b00);
      wait_settle();
      for (int i = 1; i <= 6; i++) begin
         OuterReceive       = 8'(i * 3);
         OuterReceiveValid  = 1'b1;
         InnerTransmit      = 8'(i + 8'h40);
         InnerTransmitValid = 1'b1;
         push_rx(8'(i * 3), STAGES);
         push_tx(8'(i + 8'h40), STAGES);
         step();
      end
      idle_inputs();
      checks++;
      if (InnerReceiveValid !== 1'b1 || OuterTransmitValid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midstream_active: got rx_valid=%b tx_valid=%b, required 1 1", InnerReceiveValid, OuterTransmitValid);
      end
      #2;
      Reset = 1'b1;
      #1;
      checks++;
      if (InnerReceive !== 9'd0 || InnerReceiveValid !== 1'b0 || OuterTransmit !== 8'd0 ||
          OuterTransmitValid !== 1'b0 || Settling !== 1'b1) begin
         errors++;
         $display("[TB] FAIL async_reset: got rx=%h/%b tx=%h/%b settling=%b, required 0/0 0/0 1",
                  InnerReceive, InnerReceiveValid, OuterTransmit, OuterTransmitValid, Settling);
      end
      rx_q.delete();
      tx_q.delete();
      step();
      Reset = 1'b0;
      prev_model = '0;
      wait_settle();
      repeat (4) step();
   endtask

   initial begin
      Reset = 1'b1;
      Mode  = 2'b00;
      prev_model = '0;
      idle_inputs();
      test_reset();
      test_normal_rx();
      test_transmit();
      test_extremes();
      test_loopback();
      test_bypass();
      test_mute_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/post_lna_pipe.md
# post_lna_pipe

Parametrised successor to the fixed post-LNA chain. It carries a receive path (outer to inner) and a transmit path (inner to outer) through registered pipelines of STAGES differential stages each. The receive output is the signed difference between consecutive samples, referenced to Vss (zero) after every flush. Modes are selectable at run time: normal, loopback, bypass and mute. A settle counter blanks both outputs after reset and after every mode change. The block sits between the LNA front end and the inner digit-supply logic.

## Interface
- WIDTH, 8: sample width in bits; samples are signed two's complement.
- STAGES, 4: pipeline depth per path in normal and loopback modes; minimum 1.
- SETTLE_CYCLES, 3: cycles of output blanking after reset or mode change; 0 disables blanking.

- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- Mode  in  2  00 normal, 01 loopback, 10 bypass, 11 mute.
- OuterReceive  in  WIDTH  receive sample from the LNA.
- OuterReceiveValid  in  1  qualifies OuterReceive.
- InnerReceive  out  WIDTH+1  signed difference: current sample minus previous sample.
- InnerReceiveValid  out  1  qualifies InnerReceive.
- InnerTransmit  in  WIDTH  transmit sample from the inner logic.
- InnerTransmitValid  in  1  qualifies InnerTransmit.
- OuterTransmit  out  WIDTH  transmit sample to the front end.
- OuterTransmitValid  out  1  qualifies OuterTransmit.
- Settling  out  1  high while outputs are blanked.

## Operation
- Each path is a shift pipeline of data and valid registers. It advances every cycle; there is no backpressure.
- Normal mode:
  - OuterReceive enters the receive pipeline.
  - InnerTransmit enters the transmit pipeline.
- Loopback mode:
  - InnerTransmit and InnerTransmitValid feed the receive pipeline.
  - OuterReceive is ignored.
  - The transmit pipeline input valid is forced to 0.
- Bypass mode: each path uses only its first stage, so latency is 1. Deeper stages are still clocked with valid forced to 0.
- Mute mode:
  - Both pipeline input valids are forced to 0.
  - Both output valids are 0 and both output data buses are 0.
- Differential:
  - PrevSample holds the last receive sample that left the pipeline valid.
  - When a valid sample leaves the pipeline, InnerReceive = sign-extended sample minus sign-extended PrevSample, computed at WIDTH+1 bits, which never overflows. PrevSample is then loaded with that sample.
  - PrevSample is reset to 0 by Reset and by every flush.
- Mode handling:
  - ModeQ registers Mode every cycle.
  - When Mode differs from ModeQ at a rising edge, a flush occurs at that edge: all valid registers and PrevSample are cleared, and the settle counter is loaded with SETTLE_CYCLES.
- Settle state machine:
  - States are SETTLE (counter non-zero) and RUN (counter zero).
  - In SETTLE the counter decrements each cycle. SETTLE goes to RUN when the counter reaches 0. RUN goes to SETTLE on a flush.
  - Settling = SETTLE.
  - Output valids = last-stage valid AND NOT Settling. Pipelines and PrevSample keep updating while settling.
- Simultaneous events:
  - A flush on the same edge as an input valid discards that input.
  - A mode change during SETTLE reloads the counter.

## Timing
- Reset (asynchronous) drives:
  - all outputs to 0;
  - ModeQ to 00;
  - the counter to SETTLE_CYCLES, so Settling = 1 when SETTLE_CYCLES > 0.
- Latency, input valid edge to output valid:
  - STAGES cycles in normal and loopback modes;
  - 1 cycle in bypass mode.
- After Reset deasserts, Settling stays high for exactly SETTLE_CYCLES rising edges.
- A mode change takes effect on the first edge that samples the new Mode. The flush happens on that same edge.
- Outputs are registered or a gated AND of registers; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use WIDTH=8, STAGES=4, SETTLE_CYCLES=3.
- Reset, then normal mode, settle 3 cycles, then samples 10, 25, -5 on consecutive cycles:
  - InnerReceive = 10, 15, -30, with the valid for the first sample 4 cycles after it is applied.
  - Settling is 1 for exactly 3 edges after reset release.
- Transmit in normal mode, samples 0x7F and 0x80 after settling -> OuterTransmit = 0x7F then 0x80, each 4 cycles after input.
- Differential extremes, receive 127 then -128 -> InnerReceive = 127 then -255 (9'h101), with no overflow.
- Loopback mode, InnerTransmit 20 then 30 after settling:
  - InnerReceive = 20 then 10.
  - OuterTransmitValid stays 0.
  - Values on OuterReceive have no effect.
- Mode change from normal to bypass with 2 samples in flight:
  - In-flight samples never appear.
  - Settling is high for 3 cycles.
  - The next sample 7 gives InnerReceive = 7 one cycle after it is applied.
- Mute, then Reset asserted mid-stream:
  - In mute, both valids and data are 0 while inputs toggle.
  - Reset asserted mid-cycle clears outputs immediately, without waiting for a clock edge.
